vga_pattern_gen: RTL and testbench

Pixel source stage between the VGA timing generator and the DAC pins. Consumes the generator's pixel/line counters and sync strobes, produces 4-bit-per-channel test-pattern colour with blanking, and re-times the syncs so colour and sync reach the monitor aligned. Pattern mode changes are requested over a valid/ready handshake and applied only at frame boundaries, so no frame is ever drawn with mixed patterns.

---
 rtl/vga_pattern_gen.sv | 133 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: two-stage pipeline from timing-generator counters to DAC colour,
// with syncs re-timed to match and pattern-mode changes deferred to frame boundaries.
module vga_pattern_gen #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [1:0] mode_i,
  input  logic       mode_valid_i,
  output logic       mode_ready_o,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [7:0] frame_o
);

  localparam int BAR_W = H_VISIBLE / 8;

  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_s1_q, hsync_s1_d, vsync_s1_q, vsync_s1_d;
  logic        active_q, active_d, boundary_q, boundary_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic [7:0]  frame_q, frame_d;
  logic [1:0]  mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic        pending_q, pending_d;
  logic [2:0]  bar_s, bar_inv_s;
  logic [9:0]  xs_s;

  // Stage 1: capture the generator's counters and syncs, pre-decode visibility and frame boundary.
  always_comb begin
    hcount_d   = hcount_i;
    vcount_d   = vcount_i;
    hsync_s1_d = hsync_i;
    vsync_s1_d = vsync_i;
    active_d   = (hcount_i < 10'(H_VISIBLE)) && (vcount_i < 10'(V_VISIBLE));
    boundary_d = (hcount_i == 10'd0) && (vcount_i == 10'(V_VISIBLE));
  end

  // Stage 2: pattern colour from stage-1 values; the bar index is a count of crossed bar edges.
  always_comb begin
    bar_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcount_q >= 10'(k * BAR_W)) begin
        bar_s = bar_s + 3'd1;
      end else begin
        bar_s = bar_s;
      end
    end
    bar_inv_s = 3'd7 - bar_s;
    xs_s      = hcount_q + {2'b00, frame_q};
    case (mode_q)
      2'd0:    rgb_d = 12'hFFF;
      2'd1:    rgb_d = {{4{bar_inv_s[2]}}, {4{bar_inv_s[1]}}, {4{bar_inv_s[0]}}};
      2'd2:    rgb_d = (xs_s[5] ^ vcount_q[5]) ? 12'hFFF : 12'h000;
      2'd3:    rgb_d = {hcount_q[7:4], vcount_q[7:4], frame_q[7:4]};
      default: rgb_d = 12'h000;
    endcase
    if (!active_q) begin
      rgb_d = 12'h000;
    end else begin
      rgb_d = rgb_d;
    end
    hsync_d = hsync_s1_q;
    vsync_d = vsync_s1_q;
  end

  // Frame counter and mode handshake; a pending mode is only adopted on a boundary.
  always_comb begin
    frame_d     = boundary_q ? (frame_q + 8'd1) : frame_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    if (boundary_q && pending_q) begin
      mode_d    = pend_mode_q;
      pending_d = 1'b0;
    end else if (mode_valid_i && !pending_q) begin
      pend_mode_d = mode_i;
      pending_d   = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with asynchronous reset; mode comes out of reset as colour bars.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hcount_q    <= 10'd0;
      vcount_q    <= 10'd0;
      hsync_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      active_q    <= 1'b0;
      boundary_q  <= 1'b0;
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      frame_q     <= 8'd0;
      mode_q      <= 2'd1;
      pend_mode_q <= 2'd0;
      pending_q   <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hsync_s1_q  <= hsync_s1_d;
      vsync_s1_q  <= vsync_s1_d;
      active_q    <= active_d;
      boundary_q  <= boundary_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_q     <= frame_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
    end
  end

  assign mode_ready_o = !pending_q;
  assign red_o        = rgb_q[11:8];
  assign green_o      = rgb_q[7:4];
  assign blue_o       = rgb_q[3:0];
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen: compressed frame scans and random mode requests,
// checked every cycle against an arithmetic model of the patterns, frame count and handshake.
module tb_vga_pattern_gen;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic [9:0] hcount_i, vcount_i;
  logic       hsync_i, vsync_i;
  logic [1:0] mode_i;
  logic       mode_valid_i, mode_ready_o;
  logic [3:0] red_o, green_o, blue_o;
  logic       hsync_o, vsync_o;
  logic [7:0] frame_o;

  always #5 clk_i = ~clk_i;

  vga_pattern_gen dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .mode_i(mode_i), .mode_valid_i(mode_valid_i),
    .mode_ready_o(mode_ready_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_o(frame_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the sample one step back, the mode/frame in force, the pending request.
  logic prev_vld, prev_hs, prev_vs;
  int   prev_h, prev_v;
  int   mode_m, frame_m, pmode_m;
  logic pend_m;
  logic rand_req, bnd_req;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int x, input int y, input int md, input int fr);
    int c, xs;
    if (x >= 640 || y >= 480) return 0;
    case (md)
      0: return 32'hFFF;
      1: begin
        c = 7 - x / 80;
        return ((c / 4) % 2) * 32'hF00 + ((c / 2) % 2) * 32'h0F0 + (c % 2) * 32'h00F;
      end
      2: begin
        xs = (x + fr) % 1024;
        return (((xs / 32) % 2) != ((y / 32) % 2)) ? 32'hFFF : 0;
      end
      default: return ((x / 16) % 16) * 256 + ((y / 16) % 16) * 16 + fr / 16;
    endcase
  endfunction

  task automatic model_reset();
    prev_vld = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0; prev_h = 0; prev_v = 0;
    mode_m = 1; frame_m = 0; pmode_m = 0; pend_m = 1'b0;
  endtask

  task automatic drive(input int h, input int v);
    int   exp_rgb, exp_sync;
    logic xfer;
    if (!mode_valid_i && rand_req && $urandom_range(0, 29) == 0) begin
      mode_valid_i = 1'b1;
      mode_i = 2'($urandom_range(0, 3));
    end
    if (!mode_valid_i && bnd_req && prev_vld && prev_h == 0 && prev_v == 480) begin
      mode_valid_i = 1'b1;
      mode_i = 2'($urandom_range(0, 3));
      bnd_req = 1'b0;
    end
    hcount_i = 10'(h);
    vcount_i = 10'(v);
    hsync_i  = (h >= 656 && h <= 751);
    vsync_i  = (v >= 490 && v <= 491);
    @(posedge clk_i);
    exp_rgb  = prev_vld ? pix(prev_h, prev_v, mode_m, frame_m) : 0;
    exp_sync = prev_vld ? int'({prev_hs, prev_vs}) : 0;
    xfer = mode_valid_i && !pend_m;
    if (prev_vld && prev_h == 0 && prev_v == 480) begin
      frame_m = (frame_m + 1) % 256;
      if (pend_m) begin
        mode_m = pmode_m;
        pend_m = 1'b0;
      end
    end
    if (xfer) begin
      pmode_m = int'(mode_i);
      pend_m  = 1'b1;
    end
    prev_vld = 1'b1; prev_h = h; prev_v = v; prev_hs = hsync_i; prev_vs = vsync_i;
    #1;
    check_eq("rgb", int'({red_o, green_o, blue_o}), exp_rgb);
    check_eq("sync", int'({hsync_o, vsync_o}), exp_sync);
    check_eq("frame", int'(frame_o), frame_m);
    check_eq("ready", int'(mode_ready_o), int'(!pend_m));
    if (xfer) mode_valid_i = 1'b0;
  endtask

  // A compressed frame: a handful of lines around the visible/blanking edges, ending past the boundary.
  task automatic run_frame();
    int lines[6];
    int cols[9];
    lines = '{0, $urandom_range(1, 478), $urandom_range(1, 478), 479, 480, $urandom_range(481, 524)};
    foreach (lines[i]) begin
      cols = '{0, 16, $urandom_range(1, 638), $urandom_range(1, 638), 79, 639, 640,
               $urandom_range(656, 751), $urandom_range(752, 799)};
      foreach (cols[j]) drive(cols[j], lines[i]);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_rgb", int'({red_o, green_o, blue_o}), 0);
    check_eq("rst_sync", int'({hsync_o, vsync_o}), 0);
    check_eq("rst_frame", int'(frame_o), 0);
    check_eq("rst_ready", int'(mode_ready_o), 1);
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    mode_valid_i = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin
      @(posedge clk_i);
      #1;
      check_reset_outputs();
    end
    reset_ni = 1'b1;
    model_reset();
  endtask

  task automatic request(input int m);
    mode_valid_i = 1'b1;
    mode_i = 2'(m);
  endtask

  initial begin
    reset_ni = 1'b1; hcount_i = 10'd0; vcount_i = 10'd0; hsync_i = 1'b0; vsync_i = 1'b0;
    mode_i = 2'd0; mode_valid_i = 1'b0; rand_req = 1'b0; bnd_req = 1'b0;
    model_reset();
    #2;
    do_reset();

    for (int h = 0; h < 800; h++) drive(h, 10);

    request(0);
    for (int h = 0; h < 20; h++) drive(h * 37, 100);
    repeat (2) run_frame();

    bnd_req = 1'b1;
    repeat (3) run_frame();

    rand_req = 1'b1;
    repeat (30) run_frame();
    rand_req = 1'b0;
    repeat (3) run_frame();

    request(2);
    repeat (3) run_frame();
    for (int h = 0; h < 30; h++) drive(h * 11, 200);
    do_reset();
    repeat (2) run_frame();

    request(2);
    repeat (262) run_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
